// File: rtl/jt12_kon_pkg.sv
// Shared types and helpers for the key-on slot engine.
// Channel-code validity, queue entry layout and CSM state encoding.
package jt12_kon_pkg;

    localparam int QW = 7;

    typedef enum logic [1:0] {
        CSM_IDLE = 2'd0,
        CSM_PEND = 2'd1,
        CSM_ACT  = 2'd2
    } csm_state_t;

    function automatic logic ch_valid(input int num_ch, input logic [2:0] code);
        if (num_ch == 3) return code < 3'd3;
        if (num_ch == 6) return (code != 3'd3) && (code != 3'd7);
        return 1'b1;
    endfunction

endpackage

// File: rtl/jt12_kon_fifo.sv
// Small synchronous FIFO buffering key-on register writes.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module jt12_kon_fifo
    import jt12_kon_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          push,
    input  logic          pop,
    input  logic [QW-1:0] din,
    output logic [QW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [QW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          push_ok;
    logic          pop_ok;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (en) begin
            if (rst) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push_ok) wr_ptr <= wrap_inc(wr_ptr);
                if (pop_ok)  rd_ptr <= wrap_inc(rd_ptr);
                cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
            end
        end
    end

    // Entry storage; contents are don't-care while unoccupied
    always_ff @(posedge clk) begin
        if (en && !rst && push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/jt12_kon_q.sv
// Key-on slot engine: queued register writes, per-channel key-on
// state, CSM timer-A burst, registered keyon_I for the EG.
module jt12_kon_q
    import jt12_kon_pkg::*;
#(
    parameter int NUM_CH = 6,
    parameter int QDEPTH = 4,
    parameter int CSM_CH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic [3:0] keyon_op,
    input  logic [2:0] keyon_ch,
    input  logic       up_keyon,
    input  logic [1:0] next_op,
    input  logic [2:0] next_ch,
    input  logic       csm,
    input  logic       overflow_A,
    output logic       keyon_I,
    output logic       q_full,
    output logic       q_empty,
    output logic       kon_drop,
    output logic       csm_busy
);

    if (NUM_CH != 3 && NUM_CH != 6 && NUM_CH != 8) begin : g_bad_num_ch
        $error("jt12_kon_q: NUM_CH must be 3, 6 or 8");
    end
    if (QDEPTH < 2 || QDEPTH > 8) begin : g_bad_qdepth
        $error("jt12_kon_q: QDEPTH must be 2..8");
    end
    if (CSM_CH < 0 || CSM_CH > 7 || !ch_valid(NUM_CH, 3'(CSM_CH))) begin : g_bad_csm_ch
        $error("jt12_kon_q: CSM_CH is not a valid channel code");
    end

    logic [3:0]    kon_state [8];
    logic [QW-1:0] q_dout;
    logic [2:0]    head_ch;
    logic [3:0]    head_op;
    logic          q_pop;
    logic          q_push;
    logic [3:0]    cur_bits;
    logic          csm_slot0;
    logic          csm_hit;

    csm_state_t    state;
    csm_state_t    state_n;
    logic          rearm;
    logic          rearm_n;
    logic          owed;
    logic          owed_n;
    logic          act_now;

    assign head_ch   = q_dout[6:4];
    assign head_op   = q_dout[3:0];
    assign q_pop     = !q_empty && (next_op == 2'd0) && (next_ch == head_ch);
    assign q_push    = up_keyon && ch_valid(NUM_CH, keyon_ch) && (!q_full || q_pop);
    assign cur_bits  = q_pop ? head_op : kon_state[next_ch];
    assign csm_slot0 = (next_op == 2'd0) && (next_ch == 3'(CSM_CH));
    assign csm_hit   = act_now && (next_ch == 3'(CSM_CH));
    assign csm_busy  = (state != CSM_IDLE);

    jt12_kon_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .en    (clk_en),
        .push  (q_push),
        .pop   (q_pop),
        .din   ({keyon_ch, keyon_op}),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty)
    );

    // Popped entry lands in the channel's key-on state at its op0 slot
    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (rst) begin
                for (int i = 0; i < 8; i++) kon_state[i] <= '0;
            end else if (q_pop) begin
                kon_state[head_ch] <= head_op;
            end
        end
    end

    // CSM burst state register
    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (rst) begin
                state <= CSM_IDLE;
                rearm <= 1'b0;
            end else begin
                state <= state_n;
                rearm <= rearm_n;
            end
        end
    end

    // CSM next state: a burst owed at the CSM op0 slot keys that whole frame
    always_comb begin
        owed    = (state == CSM_PEND) || ((state == CSM_ACT) && rearm);
        act_now = csm_slot0 ? owed : (state == CSM_ACT);
        owed_n  = (csm_slot0 ? 1'b0 : owed) | overflow_A;
        state_n = CSM_IDLE;
        rearm_n = 1'b0;
        if (csm) begin
            if (act_now) begin
                state_n = CSM_ACT;
                rearm_n = owed_n;
            end else if (owed_n) begin
                state_n = CSM_PEND;
            end
        end
    end

    // Registered outputs toward the envelope generator
    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (rst) begin
                keyon_I  <= 1'b0;
                kon_drop <= 1'b0;
            end else begin
                keyon_I  <= cur_bits[next_op] | csm_hit;
                kon_drop <= up_keyon && !q_push;
            end
        end
    end

endmodule
